control_sequencer: RTL
======================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter T_STEPS, default 8, number of timing steps (2..16).
REQ-002 Parameter FETCH_STEPS, default 2, leading steps that form the fetch phase (1..T_STEPS-1).
REQ-003 Parameter OP_WIDTH, default 6, opcode width; decoded output width is 2**OP_WIDTH.
REQ-004 Parameter WDT_LIMIT, default 15, maximum consecutive stall cycles (used only with the watchdog).
REQ-005 Clock  in  1  clock; all state updates on its rising edge.
REQ-006 Reset  in  1  reset; synchronous, active-high.
REQ-007 Start  in  1  single-cycle pulse that leaves IDLE.
REQ-008 Inc  in  1  advance the step counter by one.
REQ-009 EndInstr  in  1  current instruction complete; return to step 0.
REQ-010 Stall  in  1  freeze the counter (memory not ready).
REQ-011 Halt  in  1  enter HALTED.
REQ-012 OpIn  in  OP_WIDTH  opcode field from the instruction register.
REQ-013 T  out  T_STEPS  one-hot timing step.
REQ-014 D  out  2**OP_WIDTH  one-hot decode of the latched opcode.
REQ-015 Step  out  clog2(T_STEPS)  binary step index.
REQ-016 Fetch  out  1  high while Step < FETCH_STEPS in RUN.
REQ-017 State  out  2  00 IDLE, 01 RUN, 10 HALTED, 11 ERROR.
REQ-018 Overrun  out  1  sticky step-overrun error flag.

Function
REQ-019 FSM transitions: IDLE->RUN on Start; RUN->HALTED on Halt; RUN->ERROR on overrun (or on watchdog expiry when it is compiled in); HALTED and ERROR exit only via Reset.
REQ-020 In RUN, input priority is Halt > EndInstr > Stall > Inc.
REQ-021 EndInstr forces Step to 0 on the next edge, regardless of Inc or Stall.
REQ-022 Stall holds Step, and holds the opcode latch, for as long as it is asserted.
REQ-023 Inc with Step < T_STEPS-1 sets Step to Step+1 on the next edge.
REQ-024 Inc at Step = T_STEPS-1 without EndInstr is an overrun: go to ERROR, set Overrun, and do not wrap.
REQ-025 The opcode latch captures OpIn on the edge where Step = FETCH_STEPS-1 and Inc is accepted.
REQ-026 D is decoded from the latched opcode only, never from the live OpIn, so D is stable for the whole execute phase.
REQ-027 D is all-zero while Fetch = 1 or State != RUN.
REQ-028 T is one-hot of Step only in RUN; otherwise T is all-zero.
REQ-029 T, D, Fetch, State and Overrun are registered outputs or decoded purely from registered state; there is no combinational path from the inputs to the outputs.
REQ-030 Start is ignored outside IDLE; Inc, EndInstr, Stall and Halt are ignored in IDLE.
REQ-031 Halt and EndInstr asserted in the same cycle: Halt wins, and Step is frozen.

Reset
REQ-032 Reset has priority over every other input, including mid-instruction and in ERROR.
REQ-033 Reset values: State = IDLE, Step = 0, opcode latch = 0, T = 0, D = 0, Fetch = 0, Overrun = 0, watchdog count = 0.
REQ-034 Start asserted in the same cycle as Reset is ignored.

Configuration
REQ-035 Macro CTRL_SEQ_WATCHDOG_EN, when defined, adds a stall counter: it increments on each RUN cycle with Stall = 1 and clears on any cycle with Stall = 0.
REQ-036 With CTRL_SEQ_WATCHDOG_EN defined, a count exceeding WDT_LIMIT moves the FSM to ERROR on the next edge; Overrun is not set.
REQ-037 Without CTRL_SEQ_WATCHDOG_EN, the counter logic is absent and Stall may be held indefinitely.

Verification (defaults unless stated)
REQ-038 Reset, Start, Inc x2 with OpIn = 6'h05 -> T = 8'h01, 8'h02, 8'h04; Fetch falls at step 2; D = 64'h20.
REQ-039 At step 4: EndInstr, with Inc also high -> next cycle T = 8'h01, Fetch = 1, D = 0.
REQ-040 At step 3: Stall with Inc for 5 cycles, OpIn changing to 6'h3F -> T stays 8'h08, D stays 64'h20.
REQ-041 Inc held for 8 cycles with no EndInstr -> State = 11, Overrun = 1, T = 0; Reset -> State = 00, Overrun = 0.
REQ-042 Halt and EndInstr asserted together at step 5 -> State = 10, Step stays 5, T = 0.
REQ-043 With CTRL_SEQ_WATCHDOG_EN: Stall held for 16 cycles -> State = 11, Overrun = 0; stall of 15 cycles then released -> remains RUN.

Source files
------------

// File: rtl/control_sequencer.sv
// Instruction-cycle control sequencer: one-hot timing steps, fetch/execute phase and latched
// opcode decode. Optional stall watchdog is enabled by defining CTRL_SEQ_WATCHDOG_EN.
module control_sequencer #(
  parameter int unsigned T_STEPS     = 8,
  parameter int unsigned FETCH_STEPS = 2,
  parameter int unsigned OP_WIDTH    = 6,
  parameter int unsigned WDT_LIMIT   = 15
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Start,
  input  logic                         Inc,
  input  logic                         EndInstr,
  input  logic                         Stall,
  input  logic                         Halt,
  input  logic [OP_WIDTH-1:0]          OpIn,
  output logic [T_STEPS-1:0]           T,
  output logic [2**OP_WIDTH-1:0]       D,
  output logic [$clog2(T_STEPS)-1:0]   Step,
  output logic                         Fetch,
  output logic [1:0]                   State,
  output logic                         Overrun
);

  localparam int unsigned StepW = $clog2(T_STEPS);

  if (T_STEPS < 2 || T_STEPS > 16) begin : g_bad_t_steps
    $error("T_STEPS out of range");
  end
  if (FETCH_STEPS < 1 || FETCH_STEPS > T_STEPS - 1) begin : g_bad_fetch_steps
    $error("FETCH_STEPS out of range");
  end
  if (WDT_LIMIT == 0) begin : g_bad_wdt_limit
    $error("WDT_LIMIT must be non-zero");
  end

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRun    = 2'b01,
    StHalted = 2'b10,
    StError  = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [StepW-1:0]    step_q, step_d;
  logic [OP_WIDTH-1:0] op_q, op_d;
  logic                overrun_q, overrun_d;
  logic                wdt_expired;

`ifdef CTRL_SEQ_WATCHDOG_EN
  localparam int unsigned WdtW = $clog2(WDT_LIMIT + 2);

  logic [WdtW-1:0] wdt_q, wdt_d;

  // Saturates once past the limit so a long stall cannot wrap back into range.
  always_comb begin
    wdt_d = wdt_q;
    if (!Stall) begin
      wdt_d = '0;
    end else if (state_q == StRun && wdt_q <= WdtW'(WDT_LIMIT)) begin
      wdt_d = wdt_q + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_d;
    end
  end

  assign wdt_expired = (wdt_q > WdtW'(WDT_LIMIT));
`else
  assign wdt_expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    op_d      = op_q;
    overrun_d = overrun_q;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          state_d = StRun;
          step_d  = '0;
        end
      end
      StRun: begin
        if (Halt) begin
          state_d = StHalted;
        end else if (wdt_expired) begin
          state_d = StError;
        end else if (EndInstr) begin
          step_d = '0;
        end else if (Stall) begin
          step_d = step_q;
        end else if (Inc) begin
          if (step_q == StepW'(T_STEPS - 1)) begin
            // Overrun: step is left at the last slot rather than wrapping.
            state_d   = StError;
            overrun_d = 1'b1;
          end else begin
            step_d = step_q + 1'b1;
            if (step_q == StepW'(FETCH_STEPS - 1)) begin
              op_d = OpIn;
            end
          end
        end
      end
      StHalted: state_d = StHalted;
      StError:  state_d = StError;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= StIdle;
      step_q    <= '0;
      op_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      op_q      <= op_d;
      overrun_q <= overrun_d;
    end
  end

  // Outputs decode registered state only; D uses the latched opcode, never OpIn.
  logic in_fetch;

  always_comb begin
    T        = '0;
    D        = '0;
    in_fetch = 1'b0;
    if (state_q == StRun) begin
      T[step_q] = 1'b1;
      in_fetch  = (step_q < StepW'(FETCH_STEPS));
      if (!in_fetch) begin
        D[op_q] = 1'b1;
      end
    end
  end

  assign Fetch   = in_fetch;
  assign Step    = step_q;
  assign State   = state_q;
  assign Overrun = overrun_q;

endmodule
